// File: rtl/mdio_pkg.sv
// Shared MDIO responder definitions: FSM states, opcodes, register map, write record.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_RDATA = 3'd6,
        S_WDATA = 3'd7
    } mdio_state_e;

    localparam logic [1:0]  OP_READ    = 2'b10;
    localparam logic [1:0]  OP_WRITE   = 2'b01;

    localparam logic [4:0]  REG_CTRL   = 5'd0;
    localparam logic [4:0]  REG_STATUS = 5'd1;
    localparam logic [4:0]  REG_ID1    = 5'd2;
    localparam logic [4:0]  REG_ID2    = 5'd3;

    localparam logic [15:0] STATUS_VAL = 16'h7809;
    localparam logic [5:0]  PRE_FULL   = 6'd32;

    typedef struct packed {
        logic [4:0]  reg_addr;
        logic [15:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO pad signals plus the write-notification and error outputs of the responder.
// master = station / observer side, slave = responder side.
interface mdio_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_pulse;
    logic [4:0]  wr_reg;
    logic [15:0] wr_data;
    logic        frame_err;

    modport master (
        output mdc, mdio_i,
        input  mdio_o, mdio_oe, wr_pulse, wr_reg, wr_data, frame_err
    );

    modport slave (
        input  mdc, mdio_i,
        output mdio_o, mdio_oe, wr_pulse, wr_reg, wr_data, frame_err
    );
endinterface

// File: rtl/mdio_sync_edge.sv
// Purpose: 2-flop synchronizers for mdc/mdio and registered mdc rising-edge strobe.
// Latency: mdc_rise and the aligned mdio_s appear 3 clk_mac cycles after mdc rises.
// Backpressure: none; consumer must act on the single-cycle strobe.
module mdio_sync_edge (
    input  logic clk_mac,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [1:0] mdc_sync;
    logic [1:0] mdio_sync;
    logic       mdc_d;

    always_ff @(posedge clk_mac) begin
        if (!rst_n) begin
            mdc_sync  <= 2'b00;
            mdio_sync <= 2'b00;
            mdc_d     <= 1'b0;
            mdc_rise  <= 1'b0;
            mdio_s    <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_i};
            mdc_d     <= mdc_sync[1];
            // mdio_s is captured alongside the strobe so both describe the same edge
            mdc_rise  <= mdc_sync[1] & ~mdc_d;
            mdio_s    <= mdio_sync[1];
        end
    end

endmodule

// File: rtl/mdio_responder.sv
// Purpose: Clause-22 style MDIO responder with 32x16 register file; optional macro
//          MDIO_RESP_PREAMBLE_SUPPRESS_EN accepts ST after a single preamble 1.
// Latency: outputs update 1 clk_mac after each detected mdc edge; backpressure: none, paced by mdc.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0007,
    parameter logic [15:0] PHY_ID2  = 16'hC0F1
) (
    input  logic             clk_mac,
    input  logic             rst_n,
    mdio_responder_if.slave  bus
);
    import mdio_pkg::*;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_NEED = 6'd1;
`else
    localparam logic [5:0] PRE_NEED = PRE_FULL;
`endif

    logic        mdc_rise;
    logic        mdio_s;

    mdio_state_e state;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] sh;
    logic [15:0] next_sh;
    logic        is_write;
    logic [4:0]  reg_addr;
    logic [15:0] rd_sh;
    logic [15:0] rd_val;
    logic        mdio_o_q;
    logic        mdio_oe_q;
    logic        frame_err_q;
    logic        wr_pulse_q;
    wr_cmd_t     wr_q;
    logic        commit_now;
    logic [15:0] regs [32];

    mdio_sync_edge u_sync (
        .clk_mac  (clk_mac),
        .rst_n    (rst_n),
        .mdc      (bus.mdc),
        .mdio_i   (bus.mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    assign next_sh    = {sh[14:0], mdio_s};
    assign commit_now = mdc_rise && (state == S_WDATA) && (bit_cnt == 5'd15);

    // Address decode looks at the bit arriving now so read data is latched at end of REGAD
    always_comb begin
        rd_val = regs[next_sh[4:0]];
        case (next_sh[4:0])
            REG_STATUS: rd_val = STATUS_VAL;
            REG_ID1:    rd_val = PHY_ID1;
            REG_ID2:    rd_val = PHY_ID2;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_mac) begin
        if (!rst_n) begin
            state       <= S_PRE;
            pre_cnt     <= 6'd0;
            bit_cnt     <= 5'd0;
            sh          <= 16'd0;
            is_write    <= 1'b0;
            reg_addr    <= 5'd0;
            rd_sh       <= 16'd0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_q        <= '0;
        end else begin
            frame_err_q <= 1'b0;
            wr_pulse_q  <= commit_now;
            if (commit_now) begin
                wr_q.reg_addr <= reg_addr;
                wr_q.data     <= next_sh;
            end
            if (mdc_rise) begin
                sh      <= next_sh;
                bit_cnt <= bit_cnt + 5'd1;
                case (state)
                    S_PRE: begin
                        if (mdio_s) begin
                            if (pre_cnt != PRE_FULL) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            pre_cnt <= 6'd0;
                            if (pre_cnt >= PRE_NEED) begin
                                state   <= S_ST;
                                bit_cnt <= 5'd0;
                            end
                        end
                    end
                    S_ST: begin
                        bit_cnt <= 5'd0;
                        if (mdio_s) begin
                            state <= S_OP;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= S_PRE;
                        end
                    end
                    S_OP: begin
                        if (bit_cnt[0]) begin
                            bit_cnt <= 5'd0;
                            if (next_sh[1:0] == OP_READ || next_sh[1:0] == OP_WRITE) begin
                                is_write <= (next_sh[1:0] == OP_WRITE);
                                state    <= S_PHYAD;
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= S_PRE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= 5'd0;
                            state   <= (next_sh[4:0] == PHY_ADDR) ? S_REGAD : S_PRE;
                        end
                    end
                    S_REGAD: begin
                        if (bit_cnt == 5'd4) begin
                            bit_cnt  <= 5'd0;
                            reg_addr <= next_sh[4:0];
                            rd_sh    <= rd_val;
                            state    <= S_TA;
                        end
                    end
                    S_TA: begin
                        if (!is_write) begin
                            // first TA bit seen: take the line and drive the TA zero
                            mdio_oe_q <= 1'b1;
                            mdio_o_q  <= 1'b0;
                            bit_cnt   <= 5'd0;
                            state     <= S_RDATA;
                        end else if (bit_cnt[0]) begin
                            bit_cnt <= 5'd0;
                            state   <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (bit_cnt == 5'd16) begin
                            mdio_oe_q <= 1'b0;
                            mdio_o_q  <= 1'b0;
                            state     <= S_PRE;
                        end else begin
                            mdio_o_q <= rd_sh[15];
                            rd_sh    <= {rd_sh[14:0], 1'b0};
                        end
                    end
                    S_WDATA: begin
                        if (bit_cnt == 5'd15) state <= S_PRE;
                    end
                    default: state <= S_PRE;
                endcase
            end
        end
    end

    // Reg 0 bit 15 is a soft reset: it reloads everything and is never stored
    always_ff @(posedge clk_mac) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
        end else if (commit_now) begin
            if (reg_addr == REG_CTRL && next_sh[15]) begin
                for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
            end else if (reg_addr == REG_CTRL || reg_addr > REG_ID2) begin
                regs[reg_addr] <= next_sh;
            end
        end
    end

    assign bus.mdio_o    = mdio_o_q;
    assign bus.mdio_oe   = mdio_oe_q;
    assign bus.frame_err = frame_err_q;
    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_reg    = wr_q.reg_addr;
    assign bus.wr_data   = wr_q.data;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed MDIO frame vectors against mdio_responder, with station and pad model.
module tb_mdio_responder;

    logic clk_mac = 1'b0;
    logic rst_n;
    logic sta_bit;

    always #5 clk_mac = ~clk_mac;

    mdio_responder_if bus ();

    assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : sta_bit;

    mdio_responder #(
        .PHY_ADDR (5'd1),
        .PHY_ID1  (16'h0007),
        .PHY_ID2  (16'hC0F1)
    ) dut (
        .clk_mac (clk_mac),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        int          pre;
        logic        resp;
        logic [15:0] rdata;
        int          nwr;
        int          nerr;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int oe_cnt   = 0;
    logic [4:0]  last_wr_reg  = 5'd0;
    logic [15:0] last_wr_data = 16'd0;

    always @(negedge clk_mac) begin
        if (bus.wr_pulse) begin
            wr_cnt++;
            last_wr_reg  = bus.wr_reg;
            last_wr_data = bus.wr_data;
        end
        if (bus.frame_err) err_cnt++;
        if (bus.mdio_oe)   oe_cnt++;
    end

    function automatic vec_t mk(input logic [1:0] st, input logic [1:0] op,
                                input logic [4:0] phy, input logic [4:0] regad,
                                input logic [15:0] wdata, input int pre,
                                input logic resp, input logic [15:0] rdata,
                                input int nwr, input int nerr);
        vec_t v;
        v.st = st; v.op = op; v.phy = phy; v.regad = regad; v.wdata = wdata;
        v.pre = pre; v.resp = resp; v.rdata = rdata; v.nwr = nwr; v.nerr = nerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk_mac);
    endtask

    // One mdc period: station drives b while mdc is low, samples the pad just before the rise
    task automatic mdc_bit(input logic b, output logic line, output logic oe);
        bus.mdc = 1'b0;
        sta_bit = b;
        clk_n(8);
        line = bus.mdio_i;
        oe   = bus.mdio_oe;
        bus.mdc = 1'b1;
        clk_n(8);
    endtask

    task automatic send_hdr(input vec_t v);
        logic l, o;
        for (int i = 0; i < v.pre; i++) mdc_bit(1'b1, l, o);
        for (int i = 1; i >= 0; i--) mdc_bit(v.st[i], l, o);
        for (int i = 1; i >= 0; i--) mdc_bit(v.op[i], l, o);
        for (int i = 4; i >= 0; i--) mdc_bit(v.phy[i], l, o);
        for (int i = 4; i >= 0; i--) mdc_bit(v.regad[i], l, o);
    endtask

    task automatic run_frame(input vec_t v, output logic [15:0] rd, output logic ta1_oe,
                             output logic ta2_oe, output logic ta2_line);
        logic l, o, b;
        rd = 16'd0; ta1_oe = 1'b0; ta2_oe = 1'b0; ta2_line = 1'b1;
        send_hdr(v);
        for (int i = 0; i < 18; i++) begin
            if (v.op == 2'b01) b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : v.wdata[17-i];
            else               b = 1'b1;
            mdc_bit(b, l, o);
            if (i == 0)      ta1_oe = o;
            else if (i == 1) begin ta2_oe = o; ta2_line = l; end
            else             rd[17-i] = l;
        end
        sta_bit = 1'b1;
        clk_n(4);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int w0, e0, o0;
        logic [15:0] rd;
        logic t1, t2, tl;
        w0 = wr_cnt; e0 = err_cnt; o0 = oe_cnt;
        run_frame(v, rd, t1, t2, tl);
        if (v.resp) begin
            check({tag, "_rdata"}, 32'(rd), 32'(v.rdata));
            check({tag, "_ta1_released"}, 32'(t1), 32'd0);
            check({tag, "_ta2_oe_zero"}, 32'({t2, tl}), 32'b10);
            check({tag, "_end_released"}, 32'(bus.mdio_oe), 32'd0);
        end else begin
            check({tag, "_oe_cycles"}, 32'(oe_cnt - o0), 32'd0);
        end
        check({tag, "_wr_pulses"}, 32'(wr_cnt - w0), 32'(v.nwr));
        if (v.nwr > 0) begin
            check({tag, "_wr_reg"}, 32'(last_wr_reg), 32'(v.regad));
            check({tag, "_wr_data"}, 32'(last_wr_data), 32'(v.wdata));
        end
        check({tag, "_frame_err"}, 32'(err_cnt - e0), 32'(v.nerr));
    endtask

    initial begin
        vec_t tbl[19];
        logic l, o;

        //              st     op     phy    reg    wdata     pre resp rdata    wr err
        tbl[0]  = mk(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 32, 1, 16'h0007, 0, 0);
        tbl[1]  = mk(2'b01, 2'b10, 5'd1, 5'd3, 16'h0000, 32, 1, 16'hC0F1, 0, 0);
        tbl[2]  = mk(2'b01, 2'b10, 5'd1, 5'd1, 16'h0000, 32, 1, 16'h7809, 0, 0);
        tbl[3]  = mk(2'b01, 2'b01, 5'd1, 5'd4, 16'hA5A5, 32, 0, 16'h0000, 1, 0);
        tbl[4]  = mk(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32, 1, 16'hA5A5, 0, 0);
        tbl[5]  = mk(2'b01, 2'b10, 5'd3, 5'd2, 16'h0000, 32, 0, 16'h0000, 0, 0);
        tbl[6]  = mk(2'b01, 2'b01, 5'd3, 5'd4, 16'h1234, 32, 0, 16'h0000, 0, 0);
        tbl[7]  = mk(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32, 1, 16'hA5A5, 0, 0);
        tbl[8]  = mk(2'b01, 2'b01, 5'd1, 5'd2, 16'hFFFF, 32, 0, 16'h0000, 1, 0);
        tbl[9]  = mk(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 32, 1, 16'h0007, 0, 0);
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
        tbl[10] = mk(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 31, 1, 16'h0007, 0, 0);
`else
        tbl[10] = mk(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 31, 0, 16'h0000, 0, 0);
`endif
        tbl[11] = mk(2'b01, 2'b11, 5'd1, 5'd1, 16'h0000, 32, 0, 16'h0000, 0, 1);
        tbl[12] = mk(2'b01, 2'b10, 5'd1, 5'd1, 16'h0000, 32, 1, 16'h7809, 0, 0);
        tbl[13] = mk(2'b00, 2'b10, 5'd1, 5'd1, 16'h0000, 32, 0, 16'h0000, 0, 1);
        tbl[14] = mk(2'b01, 2'b01, 5'd1, 5'd0, 16'h1234, 32, 0, 16'h0000, 1, 0);
        tbl[15] = mk(2'b01, 2'b10, 5'd1, 5'd0, 16'h0000, 32, 1, 16'h1234, 0, 0);
        tbl[16] = mk(2'b01, 2'b01, 5'd1, 5'd0, 16'h8000, 32, 0, 16'h0000, 1, 0);
        tbl[17] = mk(2'b01, 2'b10, 5'd1, 5'd0, 16'h0000, 32, 1, 16'h0000, 0, 0);
        tbl[18] = mk(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32, 1, 16'h0000, 0, 0);

        rst_n   = 1'b0;
        bus.mdc = 1'b0;
        sta_bit = 1'b1;
        clk_n(5);
        check("rst_mdio_oe",   32'(bus.mdio_oe),   32'd0);
        check("rst_mdio_o",    32'(bus.mdio_o),    32'd0);
        check("rst_wr_pulse",  32'(bus.wr_pulse),  32'd0);
        check("rst_wr_reg",    32'(bus.wr_reg),    32'd0);
        check("rst_wr_data",   32'(bus.wr_data),   32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        clk_n(5);

        for (int k = 0; k < 19; k++) apply_vec(tbl[k], $sformatf("v%0d", k));

        // Reset in the middle of read data, then confirm normal decoding and cleared registers
        apply_vec(mk(2'b01, 2'b01, 5'd1, 5'd5, 16'h00FF, 32, 0, 16'h0000, 1, 0), "wr_reg5");
        send_hdr(mk(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 32, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 9; i++) mdc_bit(1'b1, l, o);
        check("midframe_oe_driven", 32'(bus.mdio_oe), 32'd1);
        rst_n = 1'b0;
        @(posedge clk_mac);
        #1;
        check("midframe_rst_release", 32'(bus.mdio_oe), 32'd0);
        check("midframe_rst_mdio_o",  32'(bus.mdio_o),  32'd0);
        clk_n(3);
        bus.mdc = 1'b0;
        sta_bit = 1'b1;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(4);
        apply_vec(mk(2'b01, 2'b10, 5'd1, 5'd3, 16'h0000, 32, 1, 16'hC0F1, 0, 0), "post_rst_id2");
        apply_vec(mk(2'b01, 2'b10, 5'd1, 5'd5, 16'h0000, 32, 1, 16'h0000, 0, 0), "post_rst_reg5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
